aes2_cmd_master: RTL and testbench
==================================

AES2_CMD_MASTER -- requirements
Module: aes2_cmd_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the register-bus address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the register-bus data width.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set command FIFO entries (power of two, at least 2).
REQ-004 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum cycles to wait for reg_ready.
REQ-005 Parameter BASE_ADDR, default ariane_soc::AES2Base, SHALL set the AES2 peripheral byte base address.
REQ-006 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-007 rst_i  input  1  asynchronous, active-high reset.
REQ-008 cmd_valid_i  input  1  command offered.
REQ-009 cmd_ready_o  output  1  command FIFO can accept.
REQ-010 cmd_write_i  input  1  1 = write, 0 = read.
REQ-011 cmd_idx_i  input  7  AES2 word index (0..127).
REQ-012 cmd_wdata_i  input  DATA_WIDTH  write data.
REQ-013 reg_addr_o  output  ADDR_WIDTH  bus byte address.
REQ-014 reg_write_o / reg_valid_o  output  1 each  bus write strobe / request valid.
REQ-015 reg_wdata_o  output  DATA_WIDTH  bus write data; reg_wstrb_o  output  DATA_WIDTH/8  always all-ones.
REQ-016 reg_rdata_i  input  DATA_WIDTH; reg_ready_i / reg_error_i  input  1 each.
REQ-017 rsp_valid_o  output  1; rsp_ready_i  input  1; rsp_rdata_o  output  DATA_WIDTH; rsp_error_o / rsp_timeout_o  output  1 each.
REQ-018 busy_o  output  1  FIFO non-empty or FSM not IDLE; err_cnt_o  output  8  saturating error count.

Function
REQ-019 cmd_ready_o SHALL equal (FIFO count < FIFO_DEPTH) from registered count, with no same-cycle pop bypass; push SHALL occur when cmd_valid_i && cmd_ready_o.
REQ-020 FSM states IDLE, REQ, RESP: IDLE->REQ when FIFO non-empty (pop on this transition); REQ->RESP on reg_ready_i or timeout; RESP->IDLE on rsp_ready_i.
REQ-021 In REQ: reg_valid_o=1; reg_addr_o = BASE_ADDR + {idx,2'b00}; reg_write_o, reg_wdata_o SHALL be registered and stable for the whole REQ state.
REQ-022 Outside REQ: reg_valid_o=0, reg_write_o=0; reg_addr_o and reg_wdata_o hold their last values.
REQ-023 Latency: a command pushed into an empty FIFO at edge N SHALL have reg_valid_o high from edge N+1; reg_ready_i in the first REQ cycle SHALL give rsp_valid_o high from the next edge.
REQ-024 On REQ->RESP via ready: rsp_rdata_o = reg_rdata_i for reads, 0 for writes; rsp_error_o = reg_error_i; rsp_timeout_o = 0.
REQ-025 A wait counter SHALL clear on entry to REQ; if reg_ready_i is still low in the TIMEOUT_CYCLES-th REQ cycle, the FSM SHALL go to RESP with rsp_error_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-026 rsp_valid_o SHALL be high exactly in RESP, with response fields stable until rsp_ready_i.
REQ-027 err_cnt_o SHALL increment on each RESP entry with error set and saturate at 255.
REQ-028 A simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-029 rst_i high SHALL immediately force: FSM IDLE, FIFO empty, cmd_ready_o=1, reg_valid_o=0, reg_write_o=0, reg_addr_o=0, reg_wdata_o=0, rsp_valid_o=0, rsp_* data/flags=0, busy_o=0, err_cnt_o=0.
REQ-030 Reset mid-transaction SHALL abandon the outstanding bus request and queued commands with no response.

Structure
REQ-031 Package aes2_pkg SHALL hold cmd_t (write, idx, wdata), state enum, and AES2_IDX_W=7.
REQ-032 The FIFO SHALL be sub-module aes2_cmd_fifo (parameters DEPTH, cmd_t payload).

Verification
REQ-033 Write idx 2, data 0xDEADBEEF, reg_ready_i tied 1 -> reg_addr_o=BASE+0x8, reg_write_o=1 for one cycle; response error=0, rdata=0.
REQ-034 Read idx 5 with reg_ready_i delayed 3 cycles, reg_rdata_i=0x1234 -> reg_valid_o high 4 cycles, addr stable; rsp_rdata_o=0x1234.
REQ-035 reg_ready_i held 0 -> timeout after 16 REQ cycles; rsp_timeout_o=1, err_cnt_o=1.
REQ-036 Push 5 commands back-to-back with rsp_ready_i=0 -> cmd_ready_o low after 4 are queued (1 in flight); order preserved on drain.
REQ-037 Assert rst_i during REQ -> reg_valid_o drops same cycle, busy_o=0, no rsp_valid_o afterwards.

Source files
------------

// File: rtl/aes2_pkg.sv
// rtl/aes2_pkg.sv - shared types and constants for the AES2 command master
package aes2_pkg;

    localparam int AES2_IDX_W  = 7;
    localparam int AES2_DATA_W = 32;

    // Default peripheral byte base address of the AES2 block in the SoC map
    localparam logic [31:0] AES2_BASE = 32'h1010_0000;

    typedef struct packed {
        logic                   write;
        logic [AES2_IDX_W-1:0]  idx;
        logic [AES2_DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_t;

    function automatic logic [AES2_IDX_W+1:0] idx_to_offset(input logic [AES2_IDX_W-1:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/aes2_cmd_fifo.sv
// rtl/aes2_cmd_fifo.sv - command queue between the command port and the bus FSM
module aes2_cmd_fifo
    import aes2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  cmd_t push_data_i,
    input  logic pop_i,
    output cmd_t head_o,
    output logic ready_o,
    output logic empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // ready comes from the registered count only: a pop in the same cycle never frees a slot early
    assign ready_o = (count < CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign head_o  = mem[rd_ptr];
    assign do_push = push_i && ready_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/aes2_cmd_master.sv
// rtl/aes2_cmd_master.sv - queues AES2 register commands and runs them on the register bus
module aes2_cmd_master
    import aes2_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    FIFO_DEPTH     = 4,
    parameter int                    TIMEOUT_CYCLES = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(AES2_BASE)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [AES2_IDX_W-1:0]   cmd_idx_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    output logic [ADDR_WIDTH-1:0]   reg_addr_o,
    output logic                    reg_write_o,
    output logic                    reg_valid_o,
    output logic [DATA_WIDTH-1:0]   reg_wdata_o,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb_o,
    input  logic [DATA_WIDTH-1:0]   reg_rdata_i,
    input  logic                    reg_ready_i,
    input  logic                    reg_error_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_error_o,
    output logic                    rsp_timeout_o,
    output logic                    busy_o,
    output logic [7:0]              err_cnt_o
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                  state_q;
    state_t                  state_d;
    cmd_t                    cmd_in;
    cmd_t                    fifo_head;
    logic                    fifo_ready;
    logic                    fifo_empty;
    logic                    pop;
    logic                    load_rsp;
    logic                    timeout_hit;
    logic [WAIT_W-1:0]       wait_q;
    logic [ADDR_WIDTH-1:0]   req_addr_q;
    logic                    req_write_q;
    logic [DATA_WIDTH-1:0]   req_wdata_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_error_q;
    logic                    rsp_timeout_q;
    logic [7:0]              err_cnt_q;

    assign cmd_in.write = cmd_write_i;
    assign cmd_in.idx   = cmd_idx_i;
    assign cmd_in.wdata = AES2_DATA_W'(cmd_wdata_i);

    aes2_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (cmd_valid_i),
        .push_data_i (cmd_in),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .ready_o     (fifo_ready),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        load_rsp    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // a ready arriving in the last allowed cycle still wins over the timeout
                if (reg_ready_i) begin
                    load_rsp = 1'b1;
                    state_d  = ST_RESP;
                end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    load_rsp    = 1'b1;
                    timeout_hit = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_q      <= '0;
            req_addr_q  <= '0;
            req_write_q <= 1'b0;
            req_wdata_q <= '0;
        end else begin
            if (pop) begin
                wait_q      <= '0;
                req_addr_q  <= BASE_ADDR + ADDR_WIDTH'(idx_to_offset(fifo_head.idx));
                req_write_q <= fifo_head.write;
                req_wdata_q <= DATA_WIDTH'(fifo_head.wdata);
            end else if (state_q == ST_REQ) begin
                wait_q <= wait_q + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            err_cnt_q     <= '0;
        end else if (load_rsp) begin
            rsp_rdata_q   <= (timeout_hit || req_write_q) ? '0 : reg_rdata_i;
            rsp_error_q   <= timeout_hit || reg_error_i;
            rsp_timeout_q <= timeout_hit;
            if ((timeout_hit || reg_error_i) && (err_cnt_q != 8'hFF))
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign cmd_ready_o   = fifo_ready;
    assign reg_valid_o   = (state_q == ST_REQ);
    assign reg_write_o   = (state_q == ST_REQ) && req_write_q;
    assign reg_addr_o    = req_addr_q;
    assign reg_wdata_o   = req_wdata_q;
    assign reg_wstrb_o   = '1;
    assign rsp_valid_o   = (state_q == ST_RESP);
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_error_o   = rsp_error_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign busy_o        = !fifo_empty || (state_q != ST_IDLE);
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_aes2_cmd_master.sv
// tb/tb_aes2_cmd_master.sv - directed and randomized checks of aes2_cmd_master
module tb_aes2_cmd_master;

    localparam logic [31:0] BASE = 32'h1010_0000;
    localparam int          TMO  = 16;

    typedef struct {
        logic        write;
        logic [6:0]  idx;
        logic [31:0] wdata;
    } mcmd_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } mrsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [6:0]  cmd_idx_i;
    logic [31:0] cmd_wdata_i;
    logic [31:0] reg_addr_o, reg_wdata_o, reg_rdata_i, rsp_rdata_o;
    logic        reg_write_o, reg_valid_o, reg_ready_i, reg_error_i;
    logic [3:0]  reg_wstrb_o;
    logic        rsp_valid_o, rsp_ready_i, rsp_error_o, rsp_timeout_o, busy_o;
    logic [7:0]  err_cnt_o;

    always #5 clk = ~clk;

    aes2_cmd_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(TMO), .BASE_ADDR(BASE)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_idx_i(cmd_idx_i), .cmd_wdata_i(cmd_wdata_i),
        .reg_addr_o(reg_addr_o), .reg_write_o(reg_write_o), .reg_valid_o(reg_valid_o),
        .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o), .reg_rdata_i(reg_rdata_i),
        .reg_ready_i(reg_ready_i), .reg_error_i(reg_error_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_error_o(rsp_error_o), .rsp_timeout_o(rsp_timeout_o),
        .busy_o(busy_o), .err_cnt_o(err_cnt_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    mcmd_t cq[$];
    mrsp_t rq[$];
    mcmd_t cur;
    int    vcnt, acc, got_n, seen, k, d, emodel, nrsp;

    initial begin
        rst = 1'b1;
        cmd_valid_i = 0; cmd_write_i = 0; cmd_idx_i = '0; cmd_wdata_i = '0;
        reg_rdata_i = '0; reg_ready_i = 0; reg_error_i = 0; rsp_ready_i = 0;
        step(); step();
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_reg_valid", reg_valid_o, 0);
        chk("rst_reg_addr", reg_addr_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err_cnt", err_cnt_o, 0);
        chk("wstrb_ones", reg_wstrb_o, 4'hF);
        rst = 1'b0;
        step();

        // single write, bus ready tied high
        reg_ready_i = 1; reg_rdata_i = 32'hCAFE_F00D; rsp_ready_i = 1;
        cmd_valid_i = 1; cmd_write_i = 1; cmd_idx_i = 7'd2; cmd_wdata_i = 32'hDEAD_BEEF;
        step();
        cmd_valid_i = 0;
        chk("wr_not_yet_valid", reg_valid_o, 0);
        chk("wr_busy", busy_o, 1);
        step();
        chk("wr_valid", reg_valid_o, 1);
        chk("wr_addr", reg_addr_o, BASE + 32'h8);
        chk("wr_write", reg_write_o, 1);
        chk("wr_wdata", reg_wdata_o, 32'hDEAD_BEEF);
        step();
        chk("wr_valid_drop", reg_valid_o, 0);
        chk("wr_write_drop", reg_write_o, 0);
        chk("wr_addr_hold", reg_addr_o, BASE + 32'h8);
        chk("wr_rsp_valid", rsp_valid_o, 1);
        chk("wr_rsp_err", rsp_error_o, 0);
        chk("wr_rsp_rdata", rsp_rdata_o, 0);
        chk("wr_rsp_tmo", rsp_timeout_o, 0);
        step();
        chk("wr_rsp_done", rsp_valid_o, 0);
        chk("wr_idle", busy_o, 0);

        // read with ready delayed by 3 cycles
        reg_ready_i = 0; reg_rdata_i = 32'h1234; rsp_ready_i = 0;
        cmd_valid_i = 1; cmd_write_i = 0; cmd_idx_i = 7'd5;
        step();
        cmd_valid_i = 0;
        vcnt = 0; acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (reg_valid_o) begin
                vcnt++;
                if (reg_addr_o !== BASE + 32'h14) acc++;
            end
            reg_ready_i = reg_valid_o && (vcnt == 4);
            step();
        end
        chk("rd_valid_cycles", vcnt, 4);
        chk("rd_addr_unstable", acc, 0);
        chk("rd_rsp_valid", rsp_valid_o, 1);
        chk("rd_rsp_rdata", rsp_rdata_o, 32'h1234);
        chk("rd_rsp_err", rsp_error_o, 0);
        reg_ready_i = 0; rsp_ready_i = 1;
        step();
        rsp_ready_i = 0;

        // ready never comes: timeout
        cmd_valid_i = 1; cmd_write_i = 0; cmd_idx_i = 7'd9;
        step();
        cmd_valid_i = 0;
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (reg_valid_o) vcnt++;
            step();
        end
        chk("tmo_valid_cycles", vcnt, TMO);
        chk("tmo_rsp_valid", rsp_valid_o, 1);
        chk("tmo_flag", rsp_timeout_o, 1);
        chk("tmo_err", rsp_error_o, 1);
        chk("tmo_rdata", rsp_rdata_o, 0);
        chk("tmo_err_cnt", err_cnt_o, 1);
        rsp_ready_i = 1;
        step();
        rsp_ready_i = 0;

        // ready in the last allowed cycle is a normal completion
        reg_rdata_i = 32'h5555_AAAA;
        cmd_valid_i = 1; cmd_write_i = 0; cmd_idx_i = 7'd1;
        step();
        cmd_valid_i = 0;
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (reg_valid_o) vcnt++;
            reg_ready_i = reg_valid_o && (vcnt == TMO);
            step();
        end
        chk("edge_valid_cycles", vcnt, TMO);
        chk("edge_tmo", rsp_timeout_o, 0);
        chk("edge_rdata", rsp_rdata_o, 32'h5555_AAAA);
        chk("edge_err_cnt", err_cnt_o, 1);
        rsp_ready_i = 1;
        step();

        // fill queue with the response port stalled, then drain in order
        reg_ready_i = 1; rsp_ready_i = 0; acc = 0;
        for (int i = 0; i < 5; i++) begin
            if (cmd_ready_o) acc++;
            cmd_valid_i = 1; cmd_write_i = 1; cmd_idx_i = 7'(10 + i); cmd_wdata_i = 32'(i);
            step();
        end
        cmd_valid_i = 0;
        chk("fill_accepted", acc, 5);
        chk("fill_full", cmd_ready_o, 0);
        rsp_ready_i = 1; got_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (reg_valid_o) begin
                if (got_n < 4) begin
                    chk("drain_addr", reg_addr_o, BASE + 32'(4 * (11 + got_n)));
                    chk("drain_wdata", reg_wdata_o, 32'(1 + got_n));
                end
                got_n++;
            end
            step();
        end
        chk("drain_count", got_n, 4);

        // reset in the middle of a request
        reg_ready_i = 0;
        cmd_valid_i = 1; cmd_write_i = 0; cmd_idx_i = 7'd3;
        step();
        cmd_idx_i = 7'd4;
        step();
        cmd_valid_i = 0;
        chk("mid_valid", reg_valid_o, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", reg_valid_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_ready", cmd_ready_o, 1);
        chk("mid_rst_errcnt", err_cnt_o, 0);
        step();
        rst = 1'b0; reg_ready_i = 1; seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid_o || reg_valid_o) seen++;
            step();
        end
        chk("mid_no_activity", seen, 0);

        // randomized traffic against a queue model
        k = 0; d = 0; emodel = 0; nrsp = 0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            if (rsp_valid_o) begin
                if (rq.size() == 0) chk("rnd_rsp_unexpected", 1, 0);
                else begin
                    chk("rnd_rsp_rdata", rsp_rdata_o, rq[0].rdata);
                    chk("rnd_rsp_err", rsp_error_o, rq[0].err);
                    chk("rnd_rsp_tmo", rsp_timeout_o, rq[0].tmo);
                    chk("rnd_err_cnt", err_cnt_o, emodel);
                end
            end
            reg_error_i = ($urandom_range(0, 3) == 0);
            reg_rdata_i = $urandom;
            if (reg_valid_o) begin
                k++;
                if (k == 1) begin
                    if (cq.size() == 0) chk("rnd_req_unexpected", 1, 0);
                    else cur = cq.pop_front();
                    d = $urandom_range(0, 18);
                end
                chk("rnd_addr", reg_addr_o, BASE + {23'd0, cur.idx, 2'b00});
                chk("rnd_write", reg_write_o, cur.write);
                chk("rnd_wdata", reg_wdata_o, cur.wdata);
                reg_ready_i = (k == d + 1);
                if (reg_ready_i) begin
                    rq.push_back('{rdata: cur.write ? 32'h0 : reg_rdata_i, err: reg_error_i, tmo: 1'b0});
                    if (reg_error_i) emodel++;
                    k = 0;
                end else if (k == TMO) begin
                    rq.push_back('{rdata: 32'h0, err: 1'b1, tmo: 1'b1});
                    emodel++;
                    k = 0;
                end
            end else begin
                chk("rnd_idle_write", reg_write_o, 0);
                reg_ready_i = 1'($urandom_range(0, 1));
            end
            rsp_ready_i = (cyc < 1450) ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (rsp_valid_o && rsp_ready_i && rq.size() > 0) begin
                void'(rq.pop_front());
                nrsp++;
            end
            if (cyc < 1350 && $urandom_range(0, 1) == 1) begin
                cmd_valid_i = 1;
                cmd_write_i = 1'($urandom_range(0, 1));
                cmd_idx_i   = 7'($urandom_range(0, 127));
                cmd_wdata_i = $urandom;
                if (cmd_ready_o) cq.push_back('{write: cmd_write_i, idx: cmd_idx_i, wdata: cmd_wdata_i});
            end else begin
                cmd_valid_i = 0;
            end
            step();
        end
        chk("rnd_cmd_q_empty", cq.size(), 0);
        chk("rnd_rsp_q_empty", rq.size(), 0);
        chk("rnd_idle", busy_o, 0);
        chk("rnd_progress", nrsp > 20, 1);

        // error counter saturation
        reg_ready_i = 1; reg_error_i = 1; rsp_ready_i = 1;
        cmd_valid_i = 1; cmd_write_i = 1;
        for (int i = 0; i < 900; i++) begin
            cmd_idx_i = 7'(i);
            step();
        end
        cmd_valid_i = 0;
        repeat (30) step();
        chk("err_cnt_saturated", err_cnt_o, 8'hFF);
        chk("sat_idle", busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
